alu_op_sequencer: RTL and testbench

Initiator-side driver for the team's combinational 4-bit ALU (ops ADD/SUB/AND/OR/NOT A).
- Buffers operation commands in a small FIFO.
- Issues each command to the ALU's A/B/ALU_Sel inputs and waits a programmable settle time.
- Captures ALU_Out and returns it in order over a valid/ready response interface.
- Sits between a command source (test controller, microcode) and the ALU instance.

---
 rtl/alu_op_sequencer.sv | 176 +++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// ============================================================================
// Module   : alu_op_sequencer
// Brief    : Buffers ALU commands and issues them to a combinational ALU.
//            It waits a settle time, then returns each result in order.
//            Optional macro ALU_SEQ_CHAIN_EN adds cmd_chain and an accumulator
//            that can stand in for operand A.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_op_sequencer #(
    parameter int WIDTH         = 4,
    parameter int SEL_W         = 3,
    parameter int DEPTH         = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [SEL_W-1:0] cmd_sel,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
`ifdef ALU_SEQ_CHAIN_EN
    input  logic             cmd_chain,
`endif
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic             busy
);

    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CW = $clog2(DEPTH + 1);
    localparam int c_SW = $clog2(SETTLE_CYCLES + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [SEL_W-1:0] r_fifo_sel [DEPTH];
    logic [WIDTH-1:0] r_fifo_a   [DEPTH];
    logic [WIDTH-1:0] r_fifo_b   [DEPTH];
`ifdef ALU_SEQ_CHAIN_EN
    logic             r_fifo_chain [DEPTH];
    logic [WIDTH-1:0] r_acc;
`endif

    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic [1:0]       r_state;
    logic [c_SW-1:0]  r_settle;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [SEL_W-1:0] r_alu_sel;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_data;
    logic             r_rsp_err;

    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    logic             w_legal;
    logic [WIDTH-1:0] w_issue_a;

    assign w_empty   = (r_count == '0);
    assign cmd_ready = (r_count != c_CW'(DEPTH));
    assign w_push    = cmd_valid && cmd_ready;
    assign w_pop     = (r_state == S_IDLE) && !w_empty;
    assign w_legal   = (r_fifo_sel[r_rd_ptr] <= SEL_W'(4));

`ifdef ALU_SEQ_CHAIN_EN
    assign w_issue_a = r_fifo_chain[r_rd_ptr] ? r_acc : r_fifo_a[r_rd_ptr];
`else
    assign w_issue_a = r_fifo_a[r_rd_ptr];
`endif

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_sel[r_wr_ptr] <= cmd_sel;
            r_fifo_a[r_wr_ptr]   <= cmd_a;
            r_fifo_b[r_wr_ptr]   <= cmd_b;
`ifdef ALU_SEQ_CHAIN_EN
            r_fifo_chain[r_wr_ptr] <= cmd_chain;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_settle    <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_sel   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
            r_acc       <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        if (w_legal) begin
                            r_alu_a   <= w_issue_a;
                            r_alu_b   <= r_fifo_b[r_rd_ptr];
                            r_alu_sel <= r_fifo_sel[r_rd_ptr];
                            r_settle  <= c_SW'(SETTLE_CYCLES);
                            r_state   <= S_SETTLE;
                        end else begin
                            r_rsp_data  <= '0;
                            r_rsp_err   <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end
                    end
                end
                S_SETTLE: begin
                    r_settle <= r_settle - c_SW'(1);
                    if (r_settle == c_SW'(1)) begin
                        r_rsp_data  <= alu_out;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
`ifdef ALU_SEQ_CHAIN_EN
                        r_acc       <= alu_out;
`endif
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_sel   = r_alu_sel;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign busy      = (r_state != S_IDLE) || !w_empty;

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// ============================================================================
// Module   : tb_alu_op_sequencer
// Brief    : Self-checking bench for alu_op_sequencer with a behavioural ALU.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_op_sequencer;

    localparam int WIDTH = 4;
    localparam int SEL_W = 3;
    localparam int DEPTH = 4;
    localparam int SC    = 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [SEL_W-1:0] cmd_sel = '0;
    logic [WIDTH-1:0] cmd_a = '0;
    logic [WIDTH-1:0] cmd_b = '0;
    logic             cmd_chain = 1'b0;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [SEL_W-1:0] alu_sel;
    logic [WIDTH-1:0] alu_out;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic             err;
        logic [WIDTH-1:0] data;
    } rsp_t;
    rsp_t exp_q[$];

    always #5 clk = ~clk;

    alu_op_sequencer #(
        .WIDTH(WIDTH), .SEL_W(SEL_W), .DEPTH(DEPTH), .SETTLE_CYCLES(SC)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_sel(cmd_sel), .cmd_a(cmd_a), .cmd_b(cmd_b),
`ifdef ALU_SEQ_CHAIN_EN
        .cmd_chain(cmd_chain),
`endif
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
    );

    // Arithmetic meaning of each opcode, modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] ref_alu(input logic [SEL_W-1:0] s,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        int r;
        case (s)
            3'd0:    r = (int'(a) + int'(b)) % 16;
            3'd1:    r = (int'(a) - int'(b) + 16) % 16;
            3'd2:    r = int'(a & b);
            3'd3:    r = int'(a | b);
            3'd4:    r = 15 - int'(a);
            default: r = 15;
        endcase
        return r[WIDTH-1:0];
    endfunction

    function automatic rsp_t ref_rsp(input logic [SEL_W-1:0] s,
                                     input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b);
        rsp_t r;
        r.err  = (s > 3'd4);
        r.data = r.err ? '0 : ref_alu(s, a, b);
        return r;
    endfunction

    always_comb alu_out = ref_alu(alu_sel, alu_a, alu_b);

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_cmd(input logic [SEL_W-1:0] s, input logic [WIDTH-1:0] a,
                            input logic [WIDTH-1:0] b, input logic ch, output bit ok);
        cmd_valid = 1'b1; cmd_sel = s; cmd_a = a; cmd_b = b; cmd_chain = ch;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (cmd_ready) ok = 1'b1;
            @(negedge clk);
            if (ok) break;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(output logic [WIDTH-1:0] d, output logic e, output bit ok);
        rsp_ready = 1'b1;
        ok = 1'b0; d = '0; e = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (rsp_valid) begin d = rsp_data; e = rsp_err; ok = 1'b1; end
            @(negedge clk);
            if (ok) break;
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({alu_a, alu_b, alu_sel, rsp_data} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got a=%h b=%h sel=%h data=%h want all 0",
                     alu_a, alu_b, alu_sel, rsp_data);
        end
        checks++;
        if ({rsp_valid, rsp_err, busy, cmd_ready} !== 4'b0001) begin
            failures++;
            $display("FAIL reset_flags got v/e/busy/rdy=%b want 0001",
                     {rsp_valid, rsp_err, busy, cmd_ready});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_add;
        bit ok; logic [WIDTH-1:0] d; logic e;
        send_cmd(3'd0, 4'b0011, 4'b0001, 1'b0, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL add_accept got timeout want accept"); end
        @(negedge clk);
        checks++;
        if ({alu_sel, alu_a, alu_b} !== {3'b000, 4'b0011, 4'b0001}) begin
            failures++;
            $display("FAIL add_issue got sel=%b a=%b b=%b want 000 0011 0001", alu_sel, alu_a, alu_b);
        end
        repeat (SC - 1) @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++; $display("FAIL add_early_valid got %b want 0", rsp_valid);
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 4'b0100}) begin
            failures++;
            $display("FAIL add_rsp got v=%b e=%b d=%b want 1 0 0100", rsp_valid, rsp_err, rsp_data);
        end
        get_rsp(d, e, ok);
    endtask

    task automatic test_back_to_back;
        logic [SEL_W-1:0] s [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
        logic [WIDTH-1:0] a [4] = '{4'b0100, 4'b1010, 4'b1010, 4'b1100};
        logic [WIDTH-1:0] b [4] = '{4'b0001, 4'b1100, 4'b1100, 4'b0110};
        logic [WIDTH-1:0] x [4] = '{4'b0011, 4'b1000, 4'b1110, 4'b0011};
        fork
            begin
                bit ok;
                for (int i = 0; i < 4; i++) send_cmd(s[i], a[i], b[i], 1'b0, ok);
            end
            begin
                bit ok; logic [WIDTH-1:0] d; logic e;
                for (int i = 0; i < 4; i++) begin
                    get_rsp(d, e, ok);
                    checks++;
                    if (!ok || e !== 1'b0 || d !== x[i]) begin
                        failures++;
                        $display("FAIL b2b_rsp%0d got ok=%0d e=%b d=%b want e=0 d=%b", i, ok, e, d, x[i]);
                    end
                end
            end
        join
    endtask

    task automatic test_wrap_illegal;
        bit ok; logic [WIDTH-1:0] d; logic e;
        send_cmd(3'd0, 4'b1111, 4'b0001, 1'b0, ok);
        get_rsp(d, e, ok);
        checks++;
        if (!ok || e !== 1'b0 || d !== 4'b0000) begin
            failures++; $display("FAIL wrap_add got e=%b d=%b want 0 0000", e, d);
        end
        send_cmd(3'd5, 4'b0111, 4'b0010, 1'b0, ok);
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++; $display("FAIL illegal_early got v=%b want 0", rsp_valid);
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b1, 4'b0000}) begin
            failures++;
            $display("FAIL illegal_rsp got v=%b e=%b d=%b want 1 1 0000", rsp_valid, rsp_err, rsp_data);
        end
        checks++;
        if ({alu_a, alu_b, alu_sel} !== {4'b1111, 4'b0001, 3'b000}) begin
            failures++;
            $display("FAIL illegal_alu_hold got a=%b b=%b sel=%b want 1111 0001 000", alu_a, alu_b, alu_sel);
        end
        get_rsp(d, e, ok);
    endtask

    task automatic test_backpressure;
        bit ok; logic [WIDTH-1:0] d; logic e; rsp_t x;
        logic [SEL_W-1:0] s; logic [WIDTH-1:0] a, b;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s = SEL_W'($urandom_range(0, 4)); a = WIDTH'($urandom); b = WIDTH'($urandom);
            send_cmd(s, a, b, 1'b0, ok);
            checks++;
            if (!ok) begin failures++; $display("FAIL bp_accept%0d got timeout want accept", i); end
            else exp_q.push_back(ref_rsp(s, a, b));
        end
        cmd_valid = 1'b1; cmd_sel = 3'd0; cmd_a = 4'd1; cmd_b = 4'd1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
                failures++; $display("FAIL bp_full got rdy=%b busy=%b want 0 1", cmd_ready, busy);
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            get_rsp(d, e, ok);
            x = exp_q.pop_front();
            checks++;
            if (!ok || e !== x.err || d !== x.data) begin
                failures++;
                $display("FAIL bp_rsp%0d got ok=%0d e=%b d=%h want e=%b d=%h", i, ok, e, d, x.err, x.data);
            end
            if (i == 0) begin
                checks++;
                if (cmd_ready !== 1'b0) begin
                    failures++; $display("FAIL bp_ready_before_pop got %b want 0", cmd_ready);
                end
                @(negedge clk);
                checks++;
                if (cmd_ready !== 1'b1) begin
                    failures++; $display("FAIL bp_ready_after_pop got %b want 1", cmd_ready);
                end
            end
        end
    endtask

    task automatic test_random;
        localparam int N = 40;
        fork
            begin
                bit ok; logic [SEL_W-1:0] s; logic [WIDTH-1:0] a, b;
                for (int i = 0; i < N; i++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    s = SEL_W'($urandom_range(0, 7)); a = WIDTH'($urandom); b = WIDTH'($urandom);
                    send_cmd(s, a, b, 1'b0, ok);
                    if (ok) exp_q.push_back(ref_rsp(s, a, b));
                end
            end
            begin
                int got = 0; bit hold = 1'b0; rsp_t prev; rsp_t x;
                prev.err = 1'b0; prev.data = '0;
                for (int cyc = 0; cyc < 4000 && got < N; cyc++) begin
                    rsp_ready = 1'($urandom_range(0, 1));
                    if (hold) begin
                        checks++;
                        if (rsp_valid !== 1'b1 || rsp_err !== prev.err || rsp_data !== prev.data) begin
                            failures++;
                            $display("FAIL rnd_hold got v=%b e=%b d=%h want 1 %b %h",
                                     rsp_valid, rsp_err, rsp_data, prev.err, prev.data);
                        end
                    end
                    if (rsp_valid && rsp_ready) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            failures++; $display("FAIL rnd_extra got response d=%h want none", rsp_data);
                        end else begin
                            x = exp_q.pop_front();
                            if (rsp_err !== x.err || rsp_data !== x.data) begin
                                failures++;
                                $display("FAIL rnd_rsp%0d got e=%b d=%h want e=%b d=%h",
                                         got, rsp_err, rsp_data, x.err, x.data);
                            end
                        end
                        got++;
                    end
                    hold = rsp_valid && !rsp_ready;
                    prev.err = rsp_err; prev.data = rsp_data;
                    @(negedge clk);
                end
                rsp_ready = 1'b0;
                checks++;
                if (got != N) begin
                    failures++; $display("FAIL rnd_count got %0d want %0d", got, N);
                end
            end
        join
    endtask

`ifdef ALU_SEQ_CHAIN_EN
    task automatic test_chain;
        bit ok; logic [WIDTH-1:0] d; logic e;
        send_cmd(3'd0, 4'b0011, 4'b0001, 1'b0, ok);
        get_rsp(d, e, ok);
        checks++;
        if (d !== 4'b0100) begin failures++; $display("FAIL chain_seed got %b want 0100", d); end
        send_cmd(3'd6, 4'b1111, 4'b1111, 1'b0, ok);
        get_rsp(d, e, ok);
        send_cmd(3'd0, 4'b1001, 4'b0010, 1'b1, ok);
        @(negedge clk);
        checks++;
        if (alu_a !== 4'b0100) begin failures++; $display("FAIL chain_issue got a=%b want 0100", alu_a); end
        get_rsp(d, e, ok);
        checks++;
        if (!ok || e !== 1'b0 || d !== 4'b0110) begin
            failures++; $display("FAIL chain_rsp got e=%b d=%b want 0 0110", e, d);
        end
    endtask
`endif

    task automatic test_reset_midop;
        bit ok; logic [WIDTH-1:0] d; logic e;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_cmd(3'd3, 4'd5 + WIDTH'(i), 4'd6, 1'b0, ok);
        get_rsp(d, e, ok);
        checks++;
        if (!ok || e !== 1'b0 || d !== ref_alu(3'd3, 4'd5, 4'd6)) begin
            failures++; $display("FAIL rstmid_first got e=%b d=%h want 0 %h", e, d, ref_alu(3'd3, 4'd5, 4'd6));
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({alu_a, alu_b, alu_sel, rsp_data, rsp_valid, rsp_err, busy} !== '0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_clear got a=%h b=%h sel=%h d=%h v=%b e=%b busy=%b rdy=%b want 0s rdy=1",
                     alu_a, alu_b, alu_sel, rsp_data, rsp_valid, rsp_err, busy, cmd_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
                failures++; $display("FAIL rstmid_stale got v=%b busy=%b want 0 0", rsp_valid, busy);
            end
        end
        rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_back_to_back();
        test_wrap_illegal();
        test_backpressure();
        test_random();
`ifdef ALU_SEQ_CHAIN_EN
        test_chain();
`endif
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
